// File: rtl/fb_read_arbiter.sv
// ---------------------------------------------------------------------------
// fb_read_arbiter
// Shares one frame-buffer read port between NUM_REQ requesters. Arbitration
// is round-robin, and a requester may hold the port for a burst of up to
// MAX_BURST consecutive grants by raising lock together with req. The grant
// is combinational, so a read can be accepted every cycle. Read data returns
// exactly one cycle after the grant and is steered to the requester recorded
// at grant time. Addresses outside the frame complete with zero data and a
// one-cycle addr_err pulse.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-low reset
//   req       : per-requester read request (level)
//   lock      : per-requester burst-hold request, only meaningful with req
//   addr      : per-requester address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt       : one-hot grant, same cycle as the accepted request
//   rvalid    : one-hot read-data valid, one cycle after gnt
//   rdata     : shared read data, qualified by rvalid, zero otherwise
//   addr_err  : one-cycle pulse when an out-of-range access completes
//   fb_re     : frame buffer read enable
//   fb_rAddr  : frame buffer read address, zero when fb_re is low
//   fb_rData  : frame buffer data, valid one cycle after fb_re
//   busy      : a grant or a response is present this cycle
// ---------------------------------------------------------------------------
module fb_read_arbiter #(
    parameter int IMG_WIDTH  = 176,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [7:0]                    rdata,
    output logic                          addr_err,
    output logic                          fb_re,
    output logic [ADDR_WIDTH-1:0]         fb_rAddr,
    input  logic [7:0]                    fb_rData,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // One extra bit so a frame size that is an exact power of two still fits.
    localparam logic [ADDR_WIDTH:0] FB_LIMIT = (ADDR_WIDTH+1)'(IMG_WIDTH*IMG_HEIGHT);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [PTR_W-1:0]       ptr_r;
    logic [PTR_W-1:0]       owner_r;
    logic [CNT_W-1:0]       burst_cnt_r;
    logic [NUM_REQ-1:0]     rvalid_r;
    logic                   in_range_r;
    logic                   addr_err_r;

    logic                   hold_s;
    logic                   found_s;
    logic                   win_valid_s;
    logic                   win_lock_s;
    logic                   win_in_range_s;
    logic [NUM_REQ-1:0]     cand_s;
    logic [NUM_REQ-1:0]     win_onehot_s;
    logic [PTR_W-1:0]       scan_idx_s;
    logic [PTR_W-1:0]       search_idx_s;
    logic [PTR_W-1:0]       win_idx_s;
    logic [PTR_W-1:0]       ptr_nxt_s;
    logic [ADDR_WIDTH-1:0]  win_addr_s;

    // Winner selection: burst hold for the owner, otherwise round-robin from ptr.
    always_comb begin
        hold_s = (state_r == ST_LOCKED) && req[owner_r] && lock[owner_r] &&
                 (burst_cnt_r < CNT_MAX);

        // When a burst ends the old owner sits out the exit cycle, even if it
        // is the only requester left.
        cand_s = req;
        if ((state_r == ST_LOCKED) && !hold_s) begin
            cand_s[owner_r] = 1'b0;
        end else begin
            cand_s = req;
        end
        found_s = |cand_s;

        // Scan from the farthest offset down to ptr so the closest requester
        // at or after ptr is the last one written.
        scan_idx_s   = {PTR_W{1'b0}};
        search_idx_s = {PTR_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx_s   = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
            search_idx_s = cand_s[scan_idx_s] ? scan_idx_s : search_idx_s;
        end

        win_valid_s    = hold_s | found_s;
        win_idx_s      = hold_s ? owner_r : search_idx_s;
        win_lock_s     = lock[win_idx_s];
        win_addr_s     = addr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        win_in_range_s = ({1'b0, win_addr_s} < FB_LIMIT);
        win_onehot_s   = win_valid_s ?
                         ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s) :
                         {NUM_REQ{1'b0}};
        ptr_nxt_s      = (win_idx_s == LAST_IDX) ? {PTR_W{1'b0}} :
                         (win_idx_s + {{(PTR_W-1){1'b0}}, 1'b1});
    end

    // Next-state logic for the ARB / LOCKED controller.
    always_comb begin
        state_nxt_s = ST_ARB;
        case (state_r)
            ST_ARB: begin
                if (found_s && win_lock_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCKED: begin
                if (hold_s) begin
                    state_nxt_s = ST_LOCKED;
                end else if (found_s && win_lock_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // Output drive; every output is forced to zero while reset is held low.
    always_comb begin
        if (reset) begin
            gnt      = win_onehot_s;
            fb_re    = win_valid_s && win_in_range_s;
            fb_rAddr = (win_valid_s && win_in_range_s) ? win_addr_s : {ADDR_WIDTH{1'b0}};
            rvalid   = rvalid_r;
            addr_err = addr_err_r;
            rdata    = ((|rvalid_r) && in_range_r) ? fb_rData : 8'h00;
        end else begin
            gnt      = {NUM_REQ{1'b0}};
            fb_re    = 1'b0;
            fb_rAddr = {ADDR_WIDTH{1'b0}};
            rvalid   = {NUM_REQ{1'b0}};
            addr_err = 1'b0;
            rdata    = 8'h00;
        end
        busy = (|gnt) | (|rvalid);
    end

    // State, rotation pointer, burst tracking and the 1-deep response pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_ARB;
            ptr_r       <= {PTR_W{1'b0}};
            owner_r     <= {PTR_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
            rvalid_r    <= {NUM_REQ{1'b0}};
            in_range_r  <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rvalid_r   <= win_onehot_s;
            in_range_r <= win_valid_s && win_in_range_s;
            addr_err_r <= win_valid_s && !win_in_range_s;

            if (win_valid_s) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end

            if (hold_s) begin
                burst_cnt_r <= (burst_cnt_r == CNT_MAX) ? CNT_MAX :
                               (burst_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
            end else if (found_s && win_lock_s) begin
                owner_r     <= win_idx_s;
                burst_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                burst_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_read_arbiter
// Self-checking bench for fb_read_arbiter. A behavioural reference arbiter
// predicts each grant; the expected response is pushed to a scoreboard queue
// and popped one cycle later when the DUT should present it. Directed
// sequences cover reset, round-robin order, burst limit, out-of-range access,
// lock release and reset mid-burst, followed by a long random run.
// ---------------------------------------------------------------------------
module tb_fb_read_arbiter;

    localparam int N     = 3;
    localparam int MAXB  = 16;
    localparam int AW    = 16;
    localparam int LIMIT = 176 * 240;

    typedef struct packed {
        logic [N-1:0] rv;
        logic [7:0]   rd;
        logic         err;
    } resp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [7:0]      rdata;
    logic            addr_err;
    logic            fb_re;
    logic [AW-1:0]   fb_rAddr;
    logic [7:0]      fb_rData;
    logic            busy;

    int checks_cnt;
    int failures_cnt;

    resp_t sb_q[$];

    // Reference arbiter state
    int m_state;
    int m_ptr;
    int m_owner;
    int m_cnt;

    // Observed outputs of the most recent step
    logic [N-1:0]  obs_gnt;
    logic [N-1:0]  obs_rvalid;
    logic [7:0]    obs_rdata;
    logic          obs_err;
    logic          obs_fbre;
    logic [AW-1:0] obs_fbaddr;
    logic          obs_busy;

    int wait_cnt[N];

    fb_read_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .addr     (addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .addr_err (addr_err),
        .fb_re    (fb_re),
        .fb_rAddr (fb_rAddr),
        .fb_rData (fb_rData),
        .busy     (busy)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer contents as a fixed function of address.
    function automatic logic [7:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3C;
    endfunction

    // Frame buffer model: one-cycle read, garbage when not enabled.
    always @(posedge clk) begin
        fb_rData <= fb_re ? memf(fb_rAddr) : 8'hEE;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input int a);
        addr[i*AW +: AW] = AW'(a);
    endtask

    // Reference winner for the current inputs, -1 when nothing is granted.
    task automatic model_grant(output int w);
        w = -1;
        if (m_state == 1 && req[m_owner] && lock[m_owner] && m_cnt < MAXB) begin
            w = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req[j] && !(m_state == 1 && j == m_owner)) w = j;
            end
        end
    endtask

    task automatic model_update(input int w);
        if (!reset) begin
            m_state = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        end else if (w < 0) begin
            m_state = 0; m_cnt = 0;
        end else begin
            m_ptr = (w + 1) % N;
            if (m_state == 1 && w == m_owner) begin
                m_cnt++;
            end else if (lock[w]) begin
                m_state = 1; m_owner = w; m_cnt = 1;
            end else begin
                m_state = 0; m_cnt = 0;
            end
        end
    endtask

    // One clock: check the response and grant, queue the next response.
    task automatic step();
        resp_t         exp_r;
        resp_t         nxt;
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] wa;
        logic          inr;
        @(negedge clk);
        exp_r = '0;
        if (sb_q.size() > 0) exp_r = sb_q.pop_front();
        if (!reset) exp_r = '0;
        check_eq("rvalid", rvalid, exp_r.rv);
        check_eq("rdata", rdata, exp_r.rd);
        check_eq("addr_err", addr_err, exp_r.err);

        model_grant(w);
        if (!reset) w = -1;
        eg  = '0;
        wa  = '0;
        inr = 1'b0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            wa    = addr[w*AW +: AW];
            inr   = (int'(wa) < LIMIT);
        end
        check_eq("gnt", gnt, eg);
        check_eq("gnt_onehot", ($countones(gnt) <= 1), 1);
        check_eq("fb_re", fb_re, (w >= 0) && inr);
        check_eq("fb_rAddr", fb_rAddr, ((w >= 0) && inr) ? wa : '0);
        check_eq("busy", busy, (eg != '0) || (exp_r.rv != '0));

        nxt.rv  = eg;
        nxt.rd  = ((w >= 0) && inr) ? memf(wa) : 8'h00;
        nxt.err = (w >= 0) && !inr;
        sb_q.push_back(nxt);

        obs_gnt    = gnt;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        obs_err    = addr_err;
        obs_fbre   = fb_re;
        obs_fbaddr = fb_rAddr;
        obs_busy   = busy;

        for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt[i] && reset) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > N*MAXB) check_eq("starve", wait_cnt[i], N*MAXB);
        end

        @(posedge clk);
        model_update(w);
        #1;
    endtask

    logic [N-1:0] v1_exp [6];
    logic [N-1:0] v2_exp;
    int           g1_cnt;

    initial begin
        checks_cnt   = 0;
        failures_cnt = 0;
        m_state = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        sb_q.push_back('0);
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        addr  = '0;

        // Reset state, with requests pending to prove gating.
        req = 3'b111;
        step();
        step();
        check_eq("reset_gnt", obs_gnt, 3'b000);
        check_eq("reset_busy", obs_busy, 1'b0);

        // V1: plain round-robin
        reset = 1'b1;
        req   = 3'b111;
        lock  = 3'b000;
        set_addr(0, 100); set_addr(1, 2000); set_addr(2, 30000);
        v1_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("v1_gnt", obs_gnt, v1_exp[k]);
            if (k > 0) check_eq("v1_rvalid", obs_rvalid, v1_exp[k-1]);
        end

        // V2: requester 1 locked, burst limit then rotation and relock
        g1_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            req  = (k == 0) ? 3'b010 : 3'b111;
            lock = 3'b010;
            step();
            if (k < 16) v2_exp = 3'b010;
            else if (k == 16) v2_exp = 3'b100;
            else if (k == 17) v2_exp = 3'b001;
            else v2_exp = 3'b010;
            check_eq("v2_gnt", obs_gnt, v2_exp);
            if (k < 17 && obs_gnt == 3'b010) g1_cnt++;
        end
        check_eq("v2_burst_len", g1_cnt, 16);
        req = 3'b000; lock = 3'b000;
        step();
        step();

        // V3: out-of-range at the exact frame size, then last valid address
        req = 3'b001;
        set_addr(0, LIMIT);
        step();
        check_eq("v3_gnt", obs_gnt, 3'b001);
        check_eq("v3_fb_re", obs_fbre, 1'b0);
        req = 3'b000;
        step();
        check_eq("v3_rvalid", obs_rvalid, 3'b001);
        check_eq("v3_rdata", obs_rdata, 8'h00);
        check_eq("v3_err", obs_err, 1'b1);
        req = 3'b001;
        set_addr(0, LIMIT - 1);
        step();
        check_eq("v3_err_pulse", obs_err, 1'b0);
        check_eq("v3_edge_fb_re", obs_fbre, 1'b1);
        req = 3'b000;
        step();
        check_eq("v3_edge_rdata", obs_rdata, memf(AW'(LIMIT - 1)));
        check_eq("v3_edge_err", obs_err, 1'b0);

        // V4: requester 2 locks for 5 grants, then releases while 0 waits
        req  = 3'b101;
        lock = 3'b100;
        set_addr(0, 7); set_addr(2, 500);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("v4_locked_gnt", obs_gnt, 3'b100);
        end
        lock = 3'b000;
        step();
        check_eq("v4_release_gnt", obs_gnt, 3'b001);
        step();
        check_eq("v4_arb_gnt2", obs_gnt, 3'b100);
        step();
        check_eq("v4_arb_gnt0", obs_gnt, 3'b001);

        // V5: reset during a burst with a response pending
        req  = 3'b010;
        lock = 3'b010;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check_eq("v5_gnt", obs_gnt, 3'b000);
        check_eq("v5_rvalid", obs_rvalid, 3'b000);
        check_eq("v5_rdata", obs_rdata, 8'h00);
        check_eq("v5_err", obs_err, 1'b0);
        check_eq("v5_fb_re", obs_fbre, 1'b0);
        check_eq("v5_fb_rAddr", obs_fbaddr, 16'h0000);
        check_eq("v5_busy", obs_busy, 1'b0);
        step();
        reset = 1'b1;
        req   = 3'b110;
        lock  = 3'b000;
        step();
        check_eq("v5_post_gnt", obs_gnt, 3'b010);
        check_eq("v5_post_rvalid", obs_rvalid, 3'b000);

        // V6: random traffic; stalled requesters hold req and addr
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !obs_gnt[i])) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 15) == 0) set_addr(i, int'($urandom_range(LIMIT - 4, LIMIT + 60)));
                    else set_addr(i, int'($urandom_range(0, LIMIT - 1)));
                end
                lock[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // Drain the last response
        req  = '0;
        lock = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/fb_read_arbiter.md
FB_READ_ARBITER -- requirements
Module: fb_read_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  IMG_WIDTH, 176, frame width in pixels
  IMG_HEIGHT, 240, frame height in pixels
  ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width
  NUM_REQ, 3, number of read requesters (2..8)
  MAX_BURST, 16, maximum consecutive locked grants to one requester (2..256)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all logic on rising edge
  reset  input  1  synchronous, active-low reset
  req  input  NUM_REQ  per-requester read request, level
  lock  input  NUM_REQ  per-requester burst-hold request, valid only with req
  addr  input  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
  gnt  output  NUM_REQ  one-hot grant, same cycle as accepted req
  rvalid  output  NUM_REQ  one-hot read-data valid, one cycle after gnt
  rdata  output  8  read data, shared by all requesters, qualified by rvalid
  addr_err  output  1  one-cycle pulse, out-of-range access completed
  fb_re  output  1  frame buffer read enable
  fb_rAddr  output  ADDR_WIDTH  frame buffer read address
  fb_rData  input  8  frame buffer data, valid one cycle after fb_re
  busy  output  1  high when a grant or pending rvalid exists this cycle
REQ-003 Clock and reset SHALL be one clock, reset synchronous and active-low, as stated above.

Function
REQ-004 At most one gnt bit SHALL be high per cycle; gnt SHALL be zero when no req bit is high.
REQ-005 Grant SHALL be combinational from req, lock state and rotation pointer; one read accepted per cycle, no idle cycle between back-to-back grants.
REQ-006 States SHALL be ARB and LOCKED; reset enters ARB.
REQ-007 In ARB, winner SHALL be first requesting index at or after ptr (wrapping NUM_REQ-1 -> 0); on grant, ptr <= winner+1 mod NUM_REQ.
REQ-008 ARB -> LOCKED when winner has lock high; owner <= winner, burst_cnt <= 1.
REQ-009 In LOCKED, owner SHALL win unconditionally while req[owner] and lock[owner] are high and burst_cnt < MAX_BURST; each grant increments burst_cnt.
REQ-010 LOCKED -> ARB, with no grant to owner that cycle and arbitration per REQ-007, when req[owner] or lock[owner] is low, or burst_cnt == MAX_BURST; ptr is then owner+1.
REQ-011 On grant with addr < IMG_WIDTH*IMG_HEIGHT: fb_re=1, fb_rAddr=addr[winner]; otherwise fb_re=0, fb_rAddr=0.
REQ-012 fb_rAddr SHALL be 0 whenever fb_re is 0.
REQ-013 Cycle after a grant: rvalid[winner]=1; rdata=fb_rData for in-range, 8'h00 and addr_err=1 for out-of-range.
REQ-014 rdata SHALL be 8'h00 whenever no rvalid bit is high.
REQ-015 Read latency SHALL be exactly 1 cycle gnt -> rvalid, independent of contention.
REQ-016 Requester index and range flag SHALL be registered per grant (1-deep pipeline), so back-to-back grants to different requesters route data correctly.
REQ-017 Requester SHALL treat req without gnt as stalled and hold addr; the arbiter SHALL not queue requests.
REQ-018 lock without req SHALL be ignored.
REQ-019 busy = (|gnt) | (|rvalid).
REQ-020 burst_cnt width SHALL be $clog2(MAX_BURST+1); it SHALL saturate at MAX_BURST and never wrap.

Reset
REQ-021 While reset low: gnt=0, rvalid=0, rdata=0, addr_err=0, fb_re=0, fb_rAddr=0, busy=0; state=ARB, ptr=0, burst_cnt=0.
REQ-022 Reset low mid-burst or with a pending rvalid SHALL drop the pending response; no rvalid in the cycle after reset releases.
REQ-023 First cycle after reset release SHALL arbitrate normally with ptr=0.

Verification
REQ-024 Bench SHALL cover:
  V1: req=3'b111 for 6 cycles, no lock -> gnt order 001,010,100,001,010,100; rvalid same order delayed 1 cycle; rdata = memory contents at each addr.
  V2: req[1]&lock[1] held 20 cycles, req[0],req[2] high -> 16 grants to 1, then one grant to 2, then 0, then 1 relocks; burst_cnt never exceeds 16.
  V3: requester 0 addr=42240 (out of range, 176x240) -> gnt[0], fb_re=0, next cycle rvalid[0]=1, rdata=8'h00, addr_err pulse 1 cycle.
  V4: requester 2 drops lock after 5 locked grants while req[0] high -> cycle 6 grants requester 0, state ARB.
  V5: reset low during LOCKED with rvalid pending -> all outputs 0 next cycle; after release, req=3'b110 -> gnt=010.
  V6: scoreboard, random req/lock/addr 10000 cycles -> gnt one-hot, every gnt matched by exactly one rvalid 1 cycle later, no requester starved > NUM_REQ*MAX_BURST cycles.
